// File: rtl/pdn_rail_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pdn_rail_sequencer
// Purpose  : Power-up / power-down sequencer for supply rails VDD1..VDDn.
//            Rails are enabled in ascending order, each waiting for the
//            previous rail to report power-good and settle. Release disables
//            them in reverse order with a settle gap between each. A rail that
//            never reaches power-good, or drops out while enabled, forces all
//            rails off and latches a fault until software clears it.
// Ports    : clk            - sequencer clock
//            rst_n          - asynchronous active-low reset
//            pwr_req        - level request, 1 = all rails on, 0 = all off
//            settle_cycles  - settle time per rail (stable while busy)
//            timeout_cycles - power-good wait limit per rail (stable while busy)
//            rail_pg        - per-rail power-good, synchronous to clk
//            fault_clr      - level, releases the fault state
//            rail_en        - registered per-rail enable
//            pwr_ok         - all rails up and settled
//            busy           - ramp up or ramp down in progress
//            fault          - fault latched
//            fault_rail     - index of the faulting rail
// Revision : 1.0 - initial release
// ============================================================================
module pdn_rail_sequencer #(
    parameter int NUM_RAILS = 6,
    parameter int DLY_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pwr_req,
    input  logic [DLY_W-1:0]             settle_cycles,
    input  logic [DLY_W-1:0]             timeout_cycles,
    input  logic [NUM_RAILS-1:0]         rail_pg,
    input  logic                         fault_clr,
    output logic [NUM_RAILS-1:0]         rail_en,
    output logic                         pwr_ok,
    output logic                         busy,
    output logic                         fault,
    output logic [$clog2(NUM_RAILS)-1:0] fault_rail
);

    localparam int                IDX_W    = $clog2(NUM_RAILS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_RAILS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UP_WAIT   = 3'd1,
        ST_UP_SETTLE = 3'd2,
        ST_ON        = 3'd3,
        ST_DN        = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t               state_q,      state_d;
    logic [IDX_W-1:0]     idx_q,        idx_d;
    logic [DLY_W-1:0]     timer_q,      timer_d;
    logic [NUM_RAILS-1:0] rail_en_q,    rail_en_d;
    logic                 pwr_ok_q,     pwr_ok_d;
    logic                 busy_q,       busy_d;
    logic                 fault_q,      fault_d;
    logic [IDX_W-1:0]     fault_rail_q, fault_rail_d;

    // ------------------------------------------------------------------------
    // Rail-drop monitor: any enabled rail without power-good, except the rail
    // currently ramping (it is still allowed to be low in UP_WAIT). The lowest
    // offending index is reported.
    // ------------------------------------------------------------------------
    logic [NUM_RAILS-1:0] drop_vec;
    logic                 drop_hit;
    logic [IDX_W-1:0]     drop_idx;

    always_comb begin
        drop_vec = rail_en_q & ~rail_pg;
        if (state_q == ST_UP_WAIT) begin
            drop_vec[idx_q] = 1'b0;
        end
        if (!(state_q inside {ST_UP_WAIT, ST_UP_SETTLE, ST_ON})) begin
            drop_vec = '0;
        end
        drop_hit = |drop_vec;
        drop_idx = '0;
        // Descending scan so the last assignment is the lowest set index.
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (drop_vec[i]) begin
                drop_idx = IDX_W'(i);
            end
        end
    end

    logic             timeout_hit;
    logic             settle_done;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] idx_dec;

    assign timeout_hit = (timer_q == timeout_cycles);
    assign settle_done = (timer_q == settle_cycles);
    assign idx_inc     = idx_q + IDX_W'(1);
    assign idx_dec     = idx_q - IDX_W'(1);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timer_d      = timer_q + DLY_W'(1);
        rail_en_d    = rail_en_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;

        case (state_q)
            ST_IDLE: begin
                rail_en_d = '0;
                if (pwr_req) begin
                    state_d      = ST_UP_WAIT;
                    idx_d        = '0;
                    rail_en_d[0] = 1'b1;
                end
            end

            ST_UP_WAIT: begin
                if (drop_hit) begin
                    state_d      = ST_FAULT;
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = drop_idx;
                end else if (!pwr_req) begin
                    // Abort: ramp down from the rail currently being brought up.
                    state_d          = ST_DN;
                    rail_en_d[idx_q] = 1'b0;
                end else if (rail_pg[idx_q]) begin
                    // Power-good wins over a timeout expiring on the same cycle.
                    state_d = ST_UP_SETTLE;
                end else if (timeout_hit) begin
                    state_d      = ST_FAULT;
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = idx_q;
                end
            end

            ST_UP_SETTLE: begin
                if (drop_hit) begin
                    state_d      = ST_FAULT;
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = drop_idx;
                end else if (!pwr_req) begin
                    state_d          = ST_DN;
                    rail_en_d[idx_q] = 1'b0;
                end else if (settle_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ON;
                    end else begin
                        state_d            = ST_UP_WAIT;
                        idx_d              = idx_inc;
                        rail_en_d[idx_inc] = 1'b1;
                    end
                end
            end

            ST_ON: begin
                if (drop_hit) begin
                    state_d      = ST_FAULT;
                    rail_en_d    = '0;
                    fault_d      = 1'b1;
                    fault_rail_d = drop_idx;
                end else if (!pwr_req) begin
                    state_d             = ST_DN;
                    idx_d               = LAST_IDX;
                    rail_en_d[LAST_IDX] = 1'b0;
                end
            end

            ST_DN: begin
                // Power-good and requests are deliberately ignored while
                // ramping down; a new request is only honoured from IDLE.
                if (settle_done) begin
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d              = idx_dec;
                        rail_en_d[idx_dec] = 1'b0;
                        timer_d            = '0;
                    end
                end
            end

            ST_FAULT: begin
                rail_en_d = '0;
                // Requiring pwr_req low prevents an immediate re-ramp into
                // the same fault as soon as software clears it.
                if (fault_clr && !pwr_req) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                rail_en_d = '0;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // Status outputs are decoded from the next state so they are registered
    // alongside it and change on the same edge.
    assign pwr_ok_d = (state_d == ST_ON);
    assign busy_d   = (state_d inside {ST_UP_WAIT, ST_UP_SETTLE, ST_DN});

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            rail_en_q    <= '0;
            pwr_ok_q     <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            rail_en_q    <= rail_en_d;
            pwr_ok_q     <= pwr_ok_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    assign rail_en    = rail_en_q;
    assign pwr_ok     = pwr_ok_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign fault_rail = fault_rail_q;

endmodule
`default_nettype wire

// File: tb/tb_pdn_rail_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdn_rail_sequencer
// Purpose  : Self-checking bench for pdn_rail_sequencer. A simple rail plant
//            raises each rail's power-good a chosen number of cycles after its
//            enable; expected outputs per edge come from a timeline computed
//            arithmetically from the sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdn_rail_sequencer;

    localparam int N  = 6;
    localparam int DW = 8;
    localparam int IW = $clog2(N);
    localparam int NEVER = 1 << 30;

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b0;
    logic          pwr_req        = 1'b0;
    logic          fault_clr      = 1'b0;
    logic [DW-1:0] settle_cycles  = '0;
    logic [DW-1:0] timeout_cycles = '0;
    logic [N-1:0]  rail_pg        = '0;
    logic [N-1:0]  rail_en;
    logic          pwr_ok;
    logic          busy;
    logic          fault;
    logic [IW-1:0] fault_rail;

    pdn_rail_sequencer #(
        .NUM_RAILS (N),
        .DLY_W     (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwr_req        (pwr_req),
        .settle_cycles  (settle_cycles),
        .timeout_cycles (timeout_cycles),
        .rail_pg        (rail_pg),
        .fault_clr      (fault_clr),
        .rail_en        (rail_en),
        .pwr_ok         (pwr_ok),
        .busy           (busy),
        .fault          (fault),
        .fault_rail     (fault_rail)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scenario description
    int           S, T;
    int           d   [N];      // cycles from enable to power-good (plant)
    int           cnt [N];
    logic [N-1:0] pg_nat;
    int           a   [N+1];    // edge (relative to E0) at which rail k enables; a[N] = pwr_ok edge
    int           fk, fedge;    // timeout rail and its fault edge
    int           down_e;       // edge that first samples pwr_req=0 (-1: none)
    int           req_back;     // edge from which pwr_req returns to 1
    int           drop_e;       // edge that samples the forced pg drop (-1: none)
    logic [N-1:0] drop_mask;
    int           prev_frail = 0;

    // Expected values
    logic [N-1:0] x_en;
    logic         x_ok, x_busy, x_flt;
    int           x_frail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en"},    32'(rail_en),    32'd0);
        chk({tag, "_ok"},    32'(pwr_ok),     32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_fault"}, 32'(fault),      32'd0);
        chk({tag, "_frail"}, 32'(fault_rail), 32'd0);
    endtask

    function automatic int lowest(input logic [N-1:0] m);
        int r = 0;
        for (int k = N - 1; k >= 0; k--) if (m[k]) r = k;
        return r;
    endfunction

    task automatic init_scn();
        for (int k = 0; k < N; k++) begin
            cnt[k] = 0;
            d[k]   = 1;
        end
        pg_nat    = '0;
        down_e    = -1;
        req_back  = NEVER;
        drop_e    = -1;
        drop_mask = '0;
    endtask

    // Rail k enables d[k-1]+S+1 edges after rail k-1; a rail whose pg arrives
    // later than timeout+1 samples faults at its enable edge + T + 1.
    task automatic plan();
        settle_cycles  = DW'(S);
        timeout_cycles = DW'(T);
        a[0]  = 0;
        fk    = N;
        fedge = -1;
        for (int k = 0; k < N; k++) begin
            if (fk == N && d[k] > T + 1) begin
                fk    = k;
                fedge = a[k] + T + 1;
            end
            a[k+1] = (fk == N) ? a[k] + d[k] + S + 1 : NEVER;
        end
    endtask

    function automatic void exp_ramp(input int r);
        x_en = '0;
        for (int k = 0; k < N; k++) if (a[k] <= r) x_en[k] = 1'b1;
        x_ok    = (fk == N) && (r >= a[N]);
        x_busy  = !x_ok;
        x_flt   = 1'b0;
        x_frail = prev_frail;
    endfunction

    function automatic void exp_at(input int c);
        int k, idle_e;
        if (fk < N && c >= fedge) begin
            x_en = '0; x_ok = 1'b0; x_busy = 1'b0; x_flt = 1'b1; x_frail = fk;
        end else if (drop_e >= 0 && c >= drop_e) begin
            x_en = '0; x_ok = 1'b0; x_busy = 1'b0; x_flt = 1'b1; x_frail = lowest(drop_mask);
        end else if (down_e >= 0 && c >= down_e) begin
            k = 0;
            for (int j = 0; j < N; j++) if (a[j] < down_e) k = j;
            idle_e  = down_e + (k + 1) * (S + 1);
            x_ok    = 1'b0;
            x_flt   = 1'b0;
            x_frail = prev_frail;
            if (c < idle_e) begin
                x_busy = 1'b1;
                x_en   = '0;
                for (int j = 0; j <= k; j++)
                    if (c < down_e + (k - j) * (S + 1)) x_en[j] = 1'b1;
            end else if (req_back <= idle_e + 1 && c > idle_e) begin
                exp_ramp(c - idle_e - 1);
            end else begin
                x_en   = '0;
                x_busy = 1'b0;
            end
        end else begin
            exp_ramp(c);
        end
    endfunction

    // Drive L edges starting at E0 and check every edge against the timeline.
    task automatic run(input int L);
        for (int c = 0; c < L; c++) begin
            pwr_req = !(down_e >= 0 && c >= down_e && c < req_back);
            rail_pg = pg_nat & ~((c == drop_e) ? drop_mask : '0);
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                cnt[k]    = rail_en[k] ? cnt[k] + 1 : 0;
                pg_nat[k] = rail_en[k] && (cnt[k] >= d[k]);
            end
            exp_at(c);
            chk($sformatf("en@%0d", c),    32'(rail_en),    32'(x_en));
            chk($sformatf("ok@%0d", c),    32'(pwr_ok),     32'(x_ok));
            chk($sformatf("busy@%0d", c),  32'(busy),       32'(x_busy));
            chk($sformatf("fault@%0d", c), 32'(fault),      32'(x_flt));
            chk($sformatf("frail@%0d", c), 32'(fault_rail), 32'(x_frail));
        end
    endtask

    task automatic clear_fault(input int exp_rail);
        rail_pg   = '0;
        pwr_req   = 1'b1;
        fault_clr = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("clr_hold_fault", 32'(fault),      32'd1);
            chk("clr_hold_en",    32'(rail_en),    32'd0);
            chk("clr_hold_frail", 32'(fault_rail), 32'(exp_rail));
        end
        pwr_req = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_fault", 32'(fault),      32'd0);
        chk("clr_busy",  32'(busy),       32'd0);
        chk("clr_frail", 32'(fault_rail), 32'(exp_rail));
        fault_clr  = 1'b0;
        prev_frail = exp_rail;
        @(posedge clk);
        #1;
        chk("clr_idle_en", 32'(rail_en), 32'd0);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog expired observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, idle_e, r;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("idle");

        // Nominal ramp with one-cycle pg lag, then power-down from ON
        init_scn();
        S = 2; T = 10;
        for (int k = 0; k < N; k++) d[k] = 2;
        plan();
        down_e = a[N] + 3;
        run(down_e + N * (S + 1) + 3);

        // Randomised clean ramps including pg exactly on the timeout cycle
        for (int it = 0; it < 4; it++) begin
            init_scn();
            S = $urandom_range(0, 5);
            T = $urandom_range(0, 6);
            for (int k = 0; k < N; k++) d[k] = $urandom_range(1, T + 1);
            plan();
            down_e = a[N] + $urandom_range(1, 4);
            run(down_e + N * (S + 1) + 2);
        end

        // Timeout on rail 3
        init_scn();
        S = $urandom_range(0, 3); T = 4;
        for (int k = 0; k < N; k++) d[k] = 2;
        d[3] = 1000;
        plan();
        run(fedge + 3);
        clear_fault(3);

        // Timeout one cycle past the boundary on a random rail
        init_scn();
        S = $urandom_range(0, 3); T = $urandom_range(0, 6);
        r = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) d[k] = (k < r) ? T + 1 : T + 2;
        plan();
        run(fedge + 2);
        clear_fault(r);

        // Simultaneous drop of rails 1 and 4 while ON
        init_scn();
        S = 1; T = 5;
        for (int k = 0; k < N; k++) d[k] = $urandom_range(1, 3);
        plan();
        drop_mask = 6'b010010;
        drop_e    = a[N] + 2;
        run(drop_e + 3);
        clear_fault(1);

        // Random drop pattern while ON
        init_scn();
        S = $urandom_range(0, 3); T = 3;
        for (int k = 0; k < N; k++) d[k] = $urandom_range(1, 4);
        plan();
        drop_mask = N'($urandom_range(1, (1 << N) - 1));
        drop_e    = a[N] + $urandom_range(1, 5);
        run(drop_e + 2);
        clear_fault(lowest(drop_mask));

        // Random aborts anywhere in the ramp (or just after reaching ON)
        for (int it = 0; it < 3; it++) begin
            init_scn();
            S = $urandom_range(0, 4); T = $urandom_range(2, 6);
            for (int k = 0; k < N; k++) d[k] = $urandom_range(1, T + 1);
            plan();
            down_e = $urandom_range(1, a[N] + 1);
            run(down_e + N * (S + 1) + 2);
        end

        // Abort during UP_SETTLE of rail 2, re-request during DN, then the
        // ramp restarts from IDLE; stop in UP_WAIT of rail 4 and reset.
        init_scn();
        S = 2; T = 8;
        for (int k = 0; k < N; k++) d[k] = $urandom_range(1, 4);
        plan();
        e        = a[2] + d[2] + 1 + $urandom_range(0, S);
        idle_e   = e + 3 * (S + 1);
        down_e   = e;
        req_back = e + $urandom_range(1, 3 * (S + 1));
        run(idle_e + a[4] + 2);

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        prev_frail = 0;
        chk_reset("async_rst");
        @(posedge clk);
        #1;
        chk_reset("rst_hold");
        pwr_req = 1'b0;
        rail_pg = '0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("rst_idle");

        // Fresh ramp after reset
        init_scn();
        S = 1; T = 3;
        for (int k = 0; k < N; k++) d[k] = $urandom_range(1, 4);
        plan();
        down_e = a[N] + 1;
        run(down_e + N * (S + 1) + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
